norm_lzc32: RTL

Sequential 32-bit normalizer and leading-zero counter. It is the producer side of the team's one-hot diagonal shifter interface. Given an operand, it derives the left-shift amount that left-justifies the operand, emitting it as a binary count and as an 8-bit one-hot in-byte shift code (bit k set means shift by k). It also returns the normalized data. It sits ahead of the shifter and FP/CLZ datapaths and scans one byte per cycle behind valid/ready handshakes.

---
 rtl/norm_lzc32.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/norm_lzc32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : norm_lzc32                                               |
// | Description : Sequential 32-bit normalizer / leading-zero counter.     |
// |               Scans one byte per cycle from the MSB end, then applies  |
// |               a single left shift to left-justify the operand. Emits   |
// |               the count in binary and as a one-hot in-byte shift code. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module norm_lzc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_lzc,
  output logic [7:0]  out_shift,
  output logic [31:0] out_data,
  output logic        out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_data;
  logic [1:0]  r_idx;
  logic [5:0]  r_lzc;
  logic [7:0]  r_sh;
  logic        r_zero;

  logic [7:0]  w_byte;
  logic [2:0]  w_z;

  // Select the byte currently under inspection, MSB lane first.
  always_comb begin
    w_byte = 8'd0;
    case (r_idx)
      2'd3:    w_byte = r_data[31:24];
      2'd2:    w_byte = r_data[23:16];
      2'd1:    w_byte = r_data[15:8];
      default: w_byte = r_data[7:0];
    endcase
  end

  // Leading zeros within the selected byte; only meaningful when it is nonzero.
  always_comb begin
    w_z = 3'd0;
    casez (w_byte)
      8'b1???????: w_z = 3'd0;
      8'b01??????: w_z = 3'd1;
      8'b001?????: w_z = 3'd2;
      8'b0001????: w_z = 3'd3;
      8'b00001???: w_z = 3'd4;
      8'b000001??: w_z = 3'd5;
      8'b0000001?: w_z = 3'd6;
      8'b00000001: w_z = 3'd7;
      default:     w_z = 3'd0;
    endcase
  end

  // State register; reset abandons any operand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus handshake flags, which depend only on the state register.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (w_byte != 8'd0)    w_state_nxt = SHIFT;
        else if (r_idx == 2'd0) w_state_nxt = DONE;
      end
      SHIFT: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load operand, accumulate count byte by byte, then normalize once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 32'd0;
      r_idx  <= 2'd0;
      r_lzc  <= 6'd0;
      r_sh   <= 8'd0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data <= in_data;
            r_idx  <= 2'd3;
            r_lzc  <= 6'd0;
            r_sh   <= 8'd0;
            r_zero <= 1'b0;
          end
        end
        SCAN: begin
          if (w_byte != 8'd0) begin
            r_lzc <= r_lzc + {3'd0, w_z};
            r_sh  <= 8'd1 << w_z;
          end else if (r_idx != 2'd0) begin
            r_lzc <= r_lzc + 6'd8;
            r_idx <= r_idx - 2'd1;
          end else begin
            // All-zero operand: no shift is meaningful, so report zeros directly.
            r_lzc  <= 6'd32;
            r_zero <= 1'b1;
            r_data <= 32'd0;
            r_sh   <= 8'd0;
          end
        end
        SHIFT: begin
          r_data <= r_data << r_lzc;
        end
        default: ;
      endcase
    end
  end

  assign out_lzc   = r_lzc;
  assign out_shift = r_sh;
  assign out_data  = r_data;
  assign out_zero  = r_zero;

endmodule
`default_nettype wire
